// File: rtl/io_bus_responder.sv
// IO-bus responder: one-hot word decode for a 6-bit LED register, a UART TX data port
// backed by a circular FIFO, and a UART status word; queued bytes go out as 8N1 frames.
module io_bus_responder #(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic [5:0]  LEDS,
  output logic        UART_TX
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
  localparam logic [4:0]    DEPTH5   = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;

  logic          selLeds, selData, selStat;
  logic [5:0]    ledsQ, ledsD;
  logic          ovfQ, ovfD;
  logic [4:0]    countQ, countD;
  logic [PW-1:0] wrPtrQ, rdPtrQ;
  logic [7:0]    fifoMem [FIFO_DEPTH];
  txState_e      stateQ, stateD;
  logic [CW-1:0] bitCntQ, bitCntD;
  logic [2:0]    bitIdxQ, bitIdxD;
  logic [7:0]    shiftQ, shiftD;
  logic          txQ, txD;
  logic          push, pop, full, empty, accept, drop, bitDone;
  logic [31:0]   status;
  logic          unusedBits;

  // Only word-address bits 0..2 take part in decode; everything else is ignored.
  assign selLeds    = IO_mem_addr[2];
  assign selData    = IO_mem_addr[3];
  assign selStat    = IO_mem_addr[4];
  assign unusedBits = ^{IO_mem_addr[31:5], IO_mem_addr[1:0], IO_mem_wdata[31:8]};

  assign full    = (countQ == DEPTH5);
  assign empty   = (countQ == 5'd0);
  assign push    = IO_mem_wr & selData;
  assign accept  = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign bitDone = (bitCntQ == '0);

  always_comb begin
    ledsD = ledsQ;
    if (IO_mem_wr && selLeds) ledsD = IO_mem_wdata[5:0];
    ovfD = ovfQ;
    if (IO_mem_wr && selStat) ovfD = 1'b0;
    if (drop) ovfD = 1'b1;
    countD = countQ;
    case ({accept, pop})
      2'b10:   countD = countQ + 5'd1;
      2'b01:   countD = countQ - 5'd1;
      default: countD = countQ;
    endcase
  end

  always_comb begin
    stateD  = stateQ;
    bitCntD = bitCntQ;
    bitIdxD = bitIdxQ;
    shiftD  = shiftQ;
    pop     = 1'b0;
    case (stateQ)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          stateD  = START;
          bitCntD = BIT_LAST;
          shiftD  = fifoMem[rdPtrQ];
        end
      end
      START: begin
        if (bitDone) begin
          stateD  = DATA;
          bitCntD = BIT_LAST;
          bitIdxD = 3'd0;
        end else begin
          bitCntD = bitCntQ - 1'b1;
        end
      end
      DATA: begin
        if (bitDone) begin
          bitCntD = BIT_LAST;
          if (bitIdxQ == 3'd7) begin
            stateD = STOP;
          end else begin
            shiftD  = shiftQ >> 1;
            bitIdxD = bitIdxQ + 3'd1;
          end
        end else begin
          bitCntD = bitCntQ - 1'b1;
        end
      end
      STOP: begin
        // Chain straight into the next start bit so queued bytes leave with no idle gap.
        if (bitDone) begin
          if (!empty) begin
            pop     = 1'b1;
            stateD  = START;
            bitCntD = BIT_LAST;
            shiftD  = fifoMem[rdPtrQ];
          end else begin
            stateD = IDLE;
          end
        end else begin
          bitCntD = bitCntQ - 1'b1;
        end
      end
      default: stateD = IDLE;
    endcase
    case (stateD)
      START:   txD = 1'b0;
      DATA:    txD = shiftD[0];
      default: txD = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ledsQ   <= '0;
      ovfQ    <= 1'b0;
      countQ  <= '0;
      wrPtrQ  <= '0;
      rdPtrQ  <= '0;
      stateQ  <= IDLE;
      bitCntQ <= '0;
      bitIdxQ <= '0;
      shiftQ  <= '0;
      txQ     <= 1'b1;
    end else begin
      ledsQ   <= ledsD;
      ovfQ    <= ovfD;
      countQ  <= countD;
      stateQ  <= stateD;
      bitCntQ <= bitCntD;
      bitIdxQ <= bitIdxD;
      shiftQ  <= shiftD;
      txQ     <= txD;
      if (accept) wrPtrQ <= wrPtrQ + 1'b1;
      if (pop)    rdPtrQ <= rdPtrQ + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fifoMem[wrPtrQ] <= IO_mem_wdata[7:0];
  end

  assign status = {21'b0, ovfQ, full, (stateQ != IDLE), 3'b0, countQ};

  always_comb begin
    IO_mem_rdata = '0;
    if (selLeds) IO_mem_rdata = IO_mem_rdata | {26'b0, ledsQ};
    if (selStat) IO_mem_rdata = IO_mem_rdata | status;
  end

  assign LEDS    = ledsQ;
  assign UART_TX = txQ;

endmodule

// File: doc/io_bus_responder.md
# io_bus_responder

Memory-mapped IO responder on the far end of the core's IO bus (`IO_mem_addr`/`IO_mem_wdata`/`IO_mem_wr` in, `IO_mem_rdata` out). Decodes one-hot word-address bits and hosts three registers: a 6-bit LED register, a UART transmit data port backed by a small FIFO, and a UART status word. It serialises queued bytes as 8N1 frames on `UART_TX`. It sits in the SoC beside the data RAM and is selected by the core whenever `em_ADDR[22]` is set.

## Interface
- `CLK_FREQ_HZ`, default 10000000: clock frequency.
- `BAUD_RATE`, default 1000000: UART bit rate. `DIV = CLK_FREQ_HZ/BAUD_RATE` (floor) clocks per bit; `DIV` ≥ 2 is required.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Must be a power of 2 in the range 2..16.

- `clk` in 1: single clock. All state updates on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `IO_mem_addr` in 32: byte address. Word address `wa = IO_mem_addr[15:2]`. Bit 22 is ignored.
- `IO_mem_wdata` in 32: store data.
- `IO_mem_wr` in 1: one-cycle store strobe.
- `IO_mem_rdata` out 32: read data. Combinational from `IO_mem_addr` and registered state.
- `LEDS` out 6: LED register.
- `UART_TX` out 1: serial output. Idles high.

## Operation
- **Decode.** `wa[0]` selects LEDS (byte address 0x400004), `wa[1]` selects UART_DATA (0x400008), `wa[2]` selects UART_STATUS (0x400010).
  - If several select bits are set, a write goes to every selected register and a read returns the OR of the selected values.
  - If no select bit is set, a read returns 0 and a write is ignored.
- **LEDS.** A write loads `IO_mem_wdata[5:0]`. A read returns `{26'b0, LEDS}`.
- **UART_DATA.**
  - A write pushes `IO_mem_wdata[7:0]` into the FIFO.
  - If the FIFO is full and no pop happens in the same cycle, the byte is dropped and the sticky `ovf` bit is set.
  - If a push and a pop happen in the same cycle while the FIFO is full, the push is accepted and the count is unchanged.
  - A read returns 0.
- **UART_STATUS.**
  - A read returns `{21'b0, ovf[10], full[9], busy[8], 3'b0, count[4:0]}`, where `busy = (state != IDLE)`.
  - Any write clears `ovf`. Write data is ignored.
- **FIFO.** Circular buffer with wrapping read and write pointers. `count` ranges 0..FIFO_DEPTH, and `full = (count == FIFO_DEPTH)`.
- **TX FSM.** States IDLE, START, DATA, STOP. A bit counter counts DIV-1 down to 0; a bit index runs 0..7.
  - IDLE: `UART_TX` = 1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `UART_TX` = 0 for DIV cycles, then go to DATA.
  - DATA: `UART_TX` = shift[0], LSB first. Shift every DIV cycles. After 8 bits go to STOP.
  - STOP: `UART_TX` = 1 for DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- **Reset** (asynchronous, any time, including mid-frame):
  - `LEDS` = 0, FIFO empty, `ovf` = 0, state IDLE.
  - `UART_TX` = 1 immediately. `IO_mem_rdata` then reflects the reset state.
  - A partial frame is abandoned, not completed.

## Timing
- `IO_mem_rdata` has zero latency. It is valid in the same cycle as `IO_mem_addr`, because the core registers it at the end of M.
- A store at edge k:
  - is visible to reads from cycle k+1 (LEDS, count, `ovf`);
  - if the FSM is IDLE, is popped at edge k+1, and `UART_TX` falls after edge k+1.
- A frame lasts exactly 10·DIV cycles. Back-to-back queued bytes produce start bits spaced 10·DIV cycles apart.
- `busy` rises with the pop edge and falls at the end of the last stop bit when the FIFO is empty.
- Stores arrive at most one per cycle. There is no back-pressure: software polls `full` before writing.

## Test plan
- **Reset values.** Assert `resetn` = 0 mid-run → `LEDS` = 0, `UART_TX` = 1. Reading 0x400010 returns 0x00000000.
- **LEDS.** Write 0x400004 ← 0xFFFFFFEA → `LEDS` = 0x2A from the next cycle. Reading 0x400004 returns 0x0000002A, and reading 0x400000 returns 0.
- **Single frame** (DIV = 10). Write 0x55 at edge k → `UART_TX` is low for cycles k+1..k+10, then follows the bits 1,0,1,0,1,0,1,0 for 10 cycles each, then is high for 10 cycles. Status reads 0x100 during the frame and 0x000 after edge k+101.
- **Back-to-back.** Write 0x41, 0x42, 0x43 on consecutive cycles → start bits begin at k+1, k+101 and k+201. `UART_TX` never idles between frames.
- **Overflow.** With the TX busy, write 9 bytes → status shows count = 8, full = 1, ovf = 1 (0x708). The 9th byte is never transmitted. A write to 0x400010 clears `ovf` (0x308).
- **Reset mid-frame.** Pulse `resetn` low during DATA with 3 bytes queued → `UART_TX` goes high asynchronously. After release the status reads 0 and no further frames are sent.
